// File: rtl/uart_rx_cfg.sv
// Parametrised UART receiver: 2-FF input sync, 3-sample mid-bit majority vote,
// configurable data width / parity / stop bits, with parity, framing and break flags.
module uart_rx_cfg #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_rx,
  output logic                 o_rx_valid,
  output logic [DATA_BITS-1:0] o_rx_data,
  output logic                 o_parity_err,
  output logic                 o_frame_err,
  output logic                 o_break,
  output logic                 o_busy
);

  localparam logic [15:0] LastCnt   = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] MidCnt    = 16'(CLKS_PER_BIT / 2);
  localparam logic [15:0] SmpFirst  = MidCnt - 16'd1;
  localparam logic [15:0] SmpLast   = MidCnt + 16'd1;
  localparam logic [3:0]  LastBit   = 4'(DATA_BITS - 1);
  localparam logic        LastStop  = 1'(STOP_BITS - 1);
  localparam logic        HasParity = (PARITY != 0);
  localparam logic        OddParity = (PARITY == 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StDone,
    StBrkWait
  } state_e;

  state_e               state_q, state_d;
  logic                 rx_meta_q, rx_s_q;
  logic [15:0]          cnt_q, cnt_d;
  logic [3:0]           bit_idx_q, bit_idx_d;
  logic                 stop_idx_q, stop_idx_d;
  logic                 smp0_q, smp0_d;
  logic                 smp1_q, smp1_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 par_bit_q, par_bit_d;
  logic                 perr_acc_q, perr_acc_d;
  logic                 ferr_acc_q, ferr_acc_d;
  logic                 stop0_zero_q, stop0_zero_d;
  logic                 valid_q, valid_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 brk_q, brk_d;

  logic        maj;
  logic        at_vote;
  logic        wrap;
  logic [15:0] cnt_inc;
  logic        ferr_now;
  logic        brk_now;

  // The third vote sample is the live synchronised value at cnt == M+1.
  assign maj      = (smp0_q & smp1_q) | (smp0_q & rx_s_q) | (smp1_q & rx_s_q);
  assign at_vote  = (cnt_q == SmpLast);
  assign wrap     = (cnt_q == LastCnt);
  assign cnt_inc  = wrap ? 16'd0 : cnt_q + 16'd1;
  assign ferr_now = ferr_acc_q | ~maj;
  assign brk_now  = (shreg_q == '0) && (!HasParity || !par_bit_q) &&
                    ((stop_idx_q == 1'b0) ? ~maj : stop0_zero_q);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_idx_d    = bit_idx_q;
    stop_idx_d   = stop_idx_q;
    smp0_d       = smp0_q;
    smp1_d       = smp1_q;
    shreg_d      = shreg_q;
    par_bit_d    = par_bit_q;
    perr_acc_d   = perr_acc_q;
    ferr_acc_d   = ferr_acc_q;
    stop0_zero_d = stop0_zero_q;
    valid_d      = 1'b0;
    data_d       = data_q;
    perr_d       = perr_q;
    ferr_d       = ferr_q;
    brk_d        = brk_q;

    if (cnt_q == SmpFirst) smp0_d = rx_s_q;
    if (cnt_q == MidCnt)   smp1_d = rx_s_q;

    unique case (state_q)
      StIdle: begin
        cnt_d        = 16'd0;
        bit_idx_d    = 4'd0;
        stop_idx_d   = 1'b0;
        perr_acc_d   = 1'b0;
        ferr_acc_d   = 1'b0;
        stop0_zero_d = 1'b0;
        if (!rx_s_q) state_d = StStart;
      end
      StStart: begin
        cnt_d = cnt_inc;
        if (at_vote && maj) begin
          state_d = StIdle;
          cnt_d   = 16'd0;
        end else if (wrap) begin
          state_d   = StData;
          bit_idx_d = 4'd0;
        end
      end
      StData: begin
        cnt_d = cnt_inc;
        if (at_vote) shreg_d = {maj, shreg_q[DATA_BITS-1:1]};
        if (wrap) begin
          if (bit_idx_q == LastBit) begin
            state_d = HasParity ? StParity : StStop;
          end else begin
            bit_idx_d = bit_idx_q + 4'd1;
          end
        end
      end
      StParity: begin
        cnt_d = cnt_inc;
        if (at_vote) begin
          par_bit_d  = maj;
          perr_acc_d = ((^shreg_q) ^ maj) != OddParity;
        end
        if (wrap) state_d = StStop;
      end
      StStop: begin
        cnt_d = cnt_inc;
        if (at_vote) begin
          if (stop_idx_q == 1'b0) stop0_zero_d = ~maj;
          ferr_acc_d = ferr_now;
          // Leave half a bit early on the last stop bit so back-to-back frames resync.
          if (stop_idx_q == LastStop) begin
            state_d = StDone;
            cnt_d   = 16'd0;
            valid_d = 1'b1;
            data_d  = shreg_q;
            perr_d  = HasParity & perr_acc_q;
            ferr_d  = ferr_now;
            brk_d   = brk_now;
          end
        end else if (wrap) begin
          stop_idx_d = stop_idx_q + 1'b1;
        end
      end
      StDone: begin
        cnt_d   = 16'd0;
        state_d = brk_q ? StBrkWait : StIdle;
      end
      StBrkWait: begin
        cnt_d = 16'd0;
        if (rx_s_q) state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        cnt_d   = 16'd0;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rx_meta_q    <= 1'b1;
      rx_s_q       <= 1'b1;
      state_q      <= StIdle;
      cnt_q        <= 16'd0;
      bit_idx_q    <= 4'd0;
      stop_idx_q   <= 1'b0;
      smp0_q       <= 1'b0;
      smp1_q       <= 1'b0;
      shreg_q      <= '0;
      par_bit_q    <= 1'b0;
      perr_acc_q   <= 1'b0;
      ferr_acc_q   <= 1'b0;
      stop0_zero_q <= 1'b0;
      valid_q      <= 1'b0;
      data_q       <= '0;
      perr_q       <= 1'b0;
      ferr_q       <= 1'b0;
      brk_q        <= 1'b0;
    end else begin
      rx_meta_q    <= i_rx;
      rx_s_q       <= rx_meta_q;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_idx_q    <= bit_idx_d;
      stop_idx_q   <= stop_idx_d;
      smp0_q       <= smp0_d;
      smp1_q       <= smp1_d;
      shreg_q      <= shreg_d;
      par_bit_q    <= par_bit_d;
      perr_acc_q   <= perr_acc_d;
      ferr_acc_q   <= ferr_acc_d;
      stop0_zero_q <= stop0_zero_d;
      valid_q      <= valid_d;
      data_q       <= data_d;
      perr_q       <= perr_d;
      ferr_q       <= ferr_d;
      brk_q        <= brk_d;
    end
  end

  assign o_rx_valid   = valid_q;
  assign o_rx_data    = data_q;
  assign o_parity_err = perr_q;
  assign o_frame_err  = ferr_q;
  assign o_break      = brk_q;
  assign o_busy       = (state_q != StIdle);

endmodule

// File: doc/uart_rx_cfg.md
Name: uart_rx_cfg

Overview:
- Parametrised UART receiver; successor to the fixed 8N1 receiver in the serial front end.
- Configurable data width, parity and stop-bit count.
- 3-sample majority vote at mid-bit, per-frame parity/framing error flags, break detection.
- Sits between the pad-level i_rx pin and the command parser, which consumes one-cycle o_rx_valid pulses.

Parameters:
- CLKS_PER_BIT, 868: clocks per bit period; legal range 8..65535.
- DATA_BITS, 8: data bits per frame; legal range 5..9.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: 1 or 2.

Ports:
- i_clk  in  1  system clock, rising edge.
- i_rst  in  1  reset; asynchronous, active-high.
- i_rx  in  1  serial line, idle high, asynchronous to i_clk.
- o_rx_valid  out  1  one-cycle pulse: frame complete; o_rx_data and the flags are valid.
- o_rx_data  out  DATA_BITS  received word, LSB = first data bit on the line.
- o_parity_err  out  1  parity mismatch on last frame (always 0 when PARITY=0).
- o_frame_err  out  1  any stop bit sampled 0 on last frame.
- o_break  out  1  last frame was a break condition.
- o_busy  out  1  high whenever FSM is not in IDLE.

Behaviour:
- Reset (async assert, sync-safe release):
  - synchroniser FFs = 1, FSM = IDLE, counters = 0.
  - all outputs = 0, including o_rx_data.
  - Reset mid-frame aborts the frame: no o_rx_valid pulse, flags unchanged at 0.
- Input sync: 2-FF synchroniser; FSM uses only the second stage (rx_s).
- Counters:
  - Bit-period counter cnt runs 0..CLKS_PER_BIT-1, wraps to 0 each bit.
  - M = CLKS_PER_BIT/2 (integer).
  - Samples are taken at cnt = M-1, M, M+1; the bit value is the majority of the 3.
  - Counter width is 16 bits; no overflow is possible in the legal range.
- FSM states: IDLE, START, DATA, PARITY, STOP, DONE, BRK_WAIT.
- IDLE: rx_s==0 -> START, cnt=0. That cycle is Tsd, 3 clocks after i_rx is first registered low.
- START:
  - At cnt==M+1, if the majority is 1 -> IDLE: false start, no pulse, no flag change.
  - Otherwise remain in START until cnt wraps -> DATA, bit_idx=0.
- DATA:
  - The majority value is shifted in LSB-first at cnt==M+1.
  - At wrap, if bit_idx==DATA_BITS-1 -> PARITY (if PARITY!=0) else STOP; otherwise bit_idx++.
- PARITY:
  - Sample the bit; perr = (XOR(data) ^ bit) != (PARITY==1 ? 1 : 0).
  - Odd parity: total ones incl. parity bit odd. Even parity: total even.
  - At wrap -> STOP.
- STOP:
  - Each stop bit is majority-sampled; any 0 sets ferr.
  - For all but the last stop bit, wait for wrap.
  - At cnt==M+1 of the last stop bit -> DONE immediately (half-bit early exit allows resync to back-to-back frames).
- DONE (1 cycle):
  - o_rx_valid=1.
  - o_rx_data, o_parity_err, o_frame_err and o_break are loaded in the same edge as o_rx_valid rises, and hold until the next DONE.
  - Next state: BRK_WAIT if break, else IDLE.
- Break: all data bits 0, parity bit 0 (if present) and the first stop bit 0. Sets o_break=1 and o_frame_err=1; o_parity_err is reported as computed.
- BRK_WAIT: stay until rx_s==1, then IDLE. A held-low line produces exactly one break frame.
- Latency: o_rx_valid is high in cycle Tsd + (N-1)*CLKS_PER_BIT + M + 2, where N = 1 + DATA_BITS + (PARITY!=0) + STOP_BITS.
- A glitch shorter than 2 samples inside a bit's vote window does not change the bit value.
- o_busy = (state != IDLE).

Test Plan:
- 8N1 (CLKS_PER_BIT=16), send 0xA5 -> single o_rx_valid pulse at the computed latency; o_rx_data=0xA5; all flags 0; back-to-back 0x3C with zero idle gap also received correctly.
- 7E2 (DATA_BITS=7, PARITY=2, STOP_BITS=2), send 0x55 with parity 0 -> data=0x55, perr=0; repeat with parity bit forced 1 -> data=0x55, perr=1.
- 8O1, send 0x00 with stop bit forced 0 but parity bit correct (1) -> ferr=1, o_break=0; then send 0x81 normally -> ferr=0.
- Line held low for 3 frame times, then released -> exactly one pulse with data=0x00, o_break=1, ferr=1; no further pulses until the line has been high and a new start bit arrives.
- Start glitch: i_rx low for 4 clocks only -> returns to IDLE with o_busy back to 0, no o_rx_valid; one-clock glitch on data bit 3 at cnt=M -> bit still decoded correctly.
- Assert i_rst during DATA bit 4 of a frame -> all outputs 0 asynchronously, no pulse; after release, a fresh 0x5A frame is received correctly.
